store_trace_buffer: RTL
=======================

Name: store_trace_buffer

Overview:
Synthesizable, parametrised store-transaction recorder for the multicycle RV32 core. Snoops the data-memory write strobe and records every store (address, lane-aligned data, byte strobes) in a circular buffer. Benches and on-board debug logic drain the buffer through a pop port. Replaces the cycle-by-cycle store printing used in directed S-type tests; adds sb/sh/sw lane decoding, misalignment detection and overflow handling.

Parameters:
ADDR_W, 32, store address width
DATA_W, 32, data width; fixed at 32 in this generation (byte-lane logic assumes 4 lanes)
DEPTH, 16, number of entries; must be a power of 2, minimum 2
WRAP_MODE, 1, 1 = overwrite oldest entry when full; 0 = drop new stores when full

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
clear  in  1  synchronous flush of buffer, counters and flags
st_valid  in  1  store strobe (core mem_write), one cycle per store
st_addr  in  ADDR_W  store byte address (core ALU result)
st_data  in  DATA_W  store source data (rs2 value, unshifted)
st_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
rd_en  in  1  pop request
rd_valid  out  1  rd_* holds a popped entry this cycle
rd_addr  out  ADDR_W  popped address
rd_data  out  DATA_W  popped lane-aligned data, unused lanes zero
rd_strb  out  4  popped byte strobes
count  out  $clog2(DEPTH)+1  current occupancy
empty  out  1  count == 0
full  out  1  count == DEPTH
overflow  out  1  sticky: a store was lost or overwritten
misalign  out  1  sticky: a misaligned or reserved-size store was seen
drop_cnt  out  16  saturating count of lost, overwritten or rejected stores

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset or clear: all pointers and count = 0; empty = 1; full, overflow, misalign, rd_valid = 0; drop_cnt = 0; rd_addr/rd_data/rd_strb = 0. Buffer RAM contents are not reset.
- Reset takes priority over clear, and clear over push/pop. A push or pop in the same cycle as clear is discarded.
- Lane decode, with o = st_addr[1:0]:
  - byte: strb = 1<<o; data = st_data[7:0]<<(8*o).
  - half: requires o[0] = 0; strb = 3<<o; data = st_data[15:0]<<(8*o).
  - word: requires o = 0; strb = 4'hF; data = st_data.
  - Misaligned or size 11: entry not written; misalign set; drop_cnt increments.
- Push on a valid st_valid cycle:
  - Not full: write entry at wr_ptr; wr_ptr++; count++.
  - Full, WRAP_MODE = 1: overwrite oldest entry; wr_ptr++ and rd_ptr++; count unchanged; overflow set; drop_cnt++.
  - Full, WRAP_MODE = 0: store discarded; overflow set; drop_cnt++.
- Pop:
  - rd_en with not empty: the next cycle has rd_valid = 1 and rd_* = entry at the old rd_ptr; rd_ptr++; count--. One-cycle latency.
  - rd_en while empty: ignored; rd_valid = 0 next cycle; no flag change.
  - rd_valid is a single-cycle pulse per pop; rd_* hold their value until the next pop.
- Simultaneous push and pop:
  - Not empty and not full: both occur, count unchanged.
  - Empty: the push lands and the pop is ignored (no bypass).
  - Full, WRAP_MODE = 1: pop returns the oldest entry and the push fills the freed slot; no overwrite, no overflow.
- Pointers are log2(DEPTH) bits and wrap naturally. drop_cnt saturates at 16'hFFFF.

Optional Feature:
STORE_TRACE_TIMESTAMP_EN
- Defined: adds a 32-bit free-running cycle counter, cleared by reset/clear and wrapping at 2^32. Its value at the push cycle is stored with each entry and presented on an extra output port rd_time [31:0], with the same latency as rd_addr.
- Undefined: no counter, no rd_time port, no extra storage.

Test Plan:
- sw x5=0xDEADBEEF to 0x100, then pop -> rd_valid one cycle after rd_en; rd_addr = 0x100, rd_data = 0xDEADBEEF, rd_strb = 4'hF; empty = 1 afterwards.
- sb 0x12345678 to 0x103, sh 0xCAFE to 0x102 -> pops give data 0x78000000 / strb 4'h8, then data 0xCAFE0000 / strb 4'hC.
- sh to 0x101, and a store with size 11 -> no entries written; misalign = 1; drop_cnt = 2; count = 0.
- DEPTH = 4, WRAP_MODE = 1, 6 sw stores with data 1..6 -> count = 4, overflow = 1, drop_cnt = 2; pops return 3,4,5,6. Same sequence with WRAP_MODE = 0 -> pops return 1,2,3,4.
- Full buffer with push and pop in the same cycle -> count stays 4, overflow unchanged; empty buffer with push and pop in the same cycle -> count = 1, rd_valid = 0.
- Assert clear mid-run with 3 entries plus a concurrent st_valid -> next cycle count = 0, empty = 1, overflow = misalign = 0, drop_cnt = 0.

Source files
------------

// File: rtl/store_trace_if.sv
// Store-snoop, pop and status bundle for store_trace_buffer.
// rd_time exists only when STORE_TRACE_TIMESTAMP_EN is defined.
interface store_trace_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
);
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [1:0]        st_size;
  logic              rd_en;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [3:0]        rd_strb;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              misalign;
  logic [15:0]       drop_cnt;
`ifdef STORE_TRACE_TIMESTAMP_EN
  logic [31:0]       rd_time;
`endif

  modport master (
    output st_valid, st_addr, st_data, st_size, rd_en,
    input  rd_valid, rd_addr, rd_data, rd_strb, count, empty, full,
           overflow, misalign, drop_cnt
`ifdef STORE_TRACE_TIMESTAMP_EN
    , input rd_time
`endif
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, rd_en,
    output rd_valid, rd_addr, rd_data, rd_strb, count, empty, full,
           overflow, misalign, drop_cnt
`ifdef STORE_TRACE_TIMESTAMP_EN
    , output rd_time
`endif
  );
endinterface

// File: rtl/store_trace_buffer.sv
// Circular recorder of lane-decoded core stores, drained through a registered pop port.
// Optional STORE_TRACE_TIMESTAMP_EN adds a per-entry 32-bit cycle stamp on rd_time.
module store_trace_buffer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  store_trace_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam bit WRAP = (WRAP_MODE != 0);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [3:0]        mem_strb [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q, misalign_q, rd_valid_q;
  logic [15:0]   drop_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [3:0]        rd_strb_q;

  logic [1:0]        ofs;
  logic              lane_ok;
  logic [3:0]        lane_strb;
  logic [DATA_W-1:0] lane_data;
  logic full_w, empty_w, good, bad, pop_ok, write_en, overwrite, lost, grow, drop_ev;

  assign ofs = bus.st_addr[1:0];

  always_comb begin
    lane_ok   = 1'b0;
    lane_strb = 4'b0000;
    lane_data = '0;
    case (bus.st_size)
      2'b00: begin
        lane_ok   = 1'b1;
        lane_strb = 4'b0001 << ofs;
        lane_data = {{(DATA_W-8){1'b0}}, bus.st_data[7:0]} << {ofs, 3'b000};
      end
      2'b01: begin
        lane_ok   = ~ofs[0];
        lane_strb = 4'b0011 << ofs;
        lane_data = {{(DATA_W-16){1'b0}}, bus.st_data[15:0]} << {ofs, 3'b000};
      end
      2'b10: begin
        lane_ok   = (ofs == 2'b00);
        lane_strb = 4'b1111;
        lane_data = bus.st_data;
      end
      default: lane_ok = 1'b0;
    endcase
  end

  // A pop on a full wrap-mode buffer frees the slot the push lands in, so no overwrite.
  assign full_w    = (count_q == CW'(DEPTH));
  assign empty_w   = (count_q == '0);
  assign good      = bus.st_valid & lane_ok;
  assign bad       = bus.st_valid & ~lane_ok;
  assign pop_ok    = bus.rd_en & ~empty_w;
  assign write_en  = good & (~full_w | WRAP);
  assign overwrite = good & full_w & WRAP & ~pop_ok;
  assign lost      = good & full_w & ~WRAP;
  assign grow      = write_en & (~full_w | pop_ok);
  assign drop_ev   = bad | overwrite | lost;

  always_ff @(posedge clk) begin
    if (write_en && !reset && !clear) begin
      mem_addr[wr_ptr] <= bus.st_addr;
      mem_data[wr_ptr] <= lane_data;
      mem_strb[wr_ptr] <= lane_strb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
      drop_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_strb_q  <= '0;
    end else begin
      if (write_en)           wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok | overwrite) rd_ptr <= rd_ptr + 1'b1;
      case ({grow, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (overwrite | lost) overflow_q <= 1'b1;
      if (bad)              misalign_q <= 1'b1;
      if (drop_ev && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
      rd_valid_q <= pop_ok;
      if (pop_ok) begin
        rd_addr_q <= mem_addr[rd_ptr];
        rd_data_q <= mem_data[rd_ptr];
        rd_strb_q <= mem_strb[rd_ptr];
      end
    end
  end

`ifdef STORE_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] mem_time [DEPTH];
  logic [31:0] rd_time_q;

  always_ff @(posedge clk) begin
    if (write_en && !reset && !clear) mem_time[wr_ptr] <= ts_q;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ts_q      <= '0;
      rd_time_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (pop_ok) rd_time_q <= mem_time[rd_ptr];
    end
  end

  assign bus.rd_time = rd_time_q;
`endif

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_strb  = rd_strb_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.overflow = overflow_q;
  assign bus.misalign = misalign_q;
  assign bus.drop_cnt = drop_q;
endmodule
